// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of T flip-flops acting as a bounded up/down counter.
// Q only ever changes by XOR with T_VEC; START/BUSY/DONE handshake, ABORT returns to IDLE.
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic             DIR,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             ENABLE,
   output logic [WIDTH-1:0] T_VEC,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_lim;
   logic             r_dir;
   logic [WIDTH-1:0] w_tvec;
   logic [WIDTH-1:0] w_tog_up;
   logic [WIDTH-1:0] w_tog_dn;
   logic [WIDTH-1:0] w_start_val;
   logic [WIDTH-1:0] w_term;
   logic             w_capture;

   // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
   always_comb begin
      w_tog_up    = '0;
      w_tog_dn    = '0;
      w_tog_up[0] = 1'b1;
      w_tog_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_tog_up[i] = w_tog_up[i-1] & r_q[i-1];
         w_tog_dn[i] = w_tog_dn[i-1] & ~r_q[i-1];
      end
   end

   assign w_start_val = r_dir ? r_lim : '0;
   assign w_term      = r_dir ? '0 : r_lim;

   always_comb begin
      w_next    = r_state;
      w_tvec    = '0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START && !ABORT) begin
               w_capture = 1'b1;
               w_next    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (ABORT) begin
               w_next = S_IDLE;
            end else begin
               w_tvec = r_q ^ w_start_val;
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            // Terminal check precedes any toggle, so the count can never wrap.
            if (ABORT) begin
               w_next = S_IDLE;
            end else if (r_q == w_term) begin
               w_next = S_DONE;
            end else if (ENABLE) begin
               w_tvec = r_dir ? w_tog_dn : w_tog_up;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_lim   <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_q     <= r_q ^ w_tvec;
         if (w_capture) begin
            r_lim <= LIMIT;
            r_dir <= DIR;
         end
      end
   end

   assign T_VEC = RST ? '0 : w_tvec;
   assign Q     = r_q;
   assign BUSY  = (r_state == S_LOAD) || (r_state == S_RUN);
   assign DONE  = (r_state == S_DONE);

endmodule
